serial_mod_checker: RTL and testbench

Parametrised serial divisibility checker: accepts a bit stream one bit per `valid_i` cycle and tracks the running remainder of the accumulated number modulo a run-time divisor. It replaces the fixed divide-by-3 checker in the serial-input test blocks. Storage is a DIV_W-bit remainder FSM, not a wide shift register. Bit order (MSB-first or LSB-first) and divisor are latched per number at `start_i`.

---
 rtl/serial_mod_checker.sv | 122 ++++++++++++
 tb/tb_serial_mod_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mod_checker.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mod_checker
//  Purpose  : Serial divisibility checker. Tracks the running remainder of a
//             bit stream modulo a run-time divisor, MSB-first or LSB-first.
//  Revision : 1.0  initial release
// ============================================================================
module serial_mod_checker #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [DIV_W-1:0] div_val_i,
    input  logic             mode_i,
    input  logic             valid_i,
    input  logic             x_i,
    output logic [DIV_W-1:0] rem_o,
    output logic             div_o,
    output logic [CNT_W-1:0] bits_o,
    output logic             busy_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERR    = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_rem, w_rem_nxt;
    logic [DIV_W-1:0] r_pow, w_pow_nxt;
    logic [DIV_W-1:0] r_n, w_n_nxt;
    logic             r_mode, w_mode_nxt;
    logic [CNT_W-1:0] r_bits, w_bits_nxt;

    // Operands for the bit update: a start in the same cycle substitutes the
    // fresh start values so the bit lands in the new number.
    logic [DIV_W-1:0] w_n_cur, w_rem_base, w_pow_base;
    logic             w_mode_cur;
    logic [CNT_W-1:0] w_bits_base;
    logic [DIV_W:0]   w_n_ext, w_t_msb, w_t_lsb, w_t, w_p;
    logic [DIV_W-1:0] w_rem_upd, w_pow_upd;
    logic [CNT_W-1:0] w_bits_upd;

    assign w_n_cur     = start_i ? div_val_i : r_n;
    assign w_mode_cur  = start_i ? mode_i : r_mode;
    assign w_rem_base  = start_i ? '0 : r_rem;
    assign w_pow_base  = start_i ? ((div_val_i == DIV_W'(1)) ? '0 : DIV_W'(1)) : r_pow;
    assign w_bits_base = start_i ? '0 : r_bits;

    assign w_n_ext   = {1'b0, w_n_cur};
    assign w_t_msb   = {w_rem_base, x_i};
    assign w_t_lsb   = {1'b0, w_rem_base} + (x_i ? {1'b0, w_pow_base} : '0);
    assign w_t       = w_mode_cur ? w_t_lsb : w_t_msb;
    assign w_rem_upd = (w_t >= w_n_ext) ? DIV_W'(w_t - w_n_ext) : w_t[DIV_W-1:0];
    assign w_p       = {w_pow_base, 1'b0};
    assign w_pow_upd = (w_p >= w_n_ext) ? DIV_W'(w_p - w_n_ext) : w_p[DIV_W-1:0];
    assign w_bits_upd = (&w_bits_base) ? w_bits_base : w_bits_base + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_pow_nxt   = r_pow;
        w_n_nxt     = r_n;
        w_mode_nxt  = r_mode;
        w_bits_nxt  = r_bits;
        if (start_i) begin
            w_n_nxt    = div_val_i;
            w_mode_nxt = mode_i;
            if (div_val_i == '0) begin
                w_state_nxt = S_ERR;
                w_rem_nxt   = '0;
                w_pow_nxt   = '0;
                w_bits_nxt  = '0;
            end else begin
                w_state_nxt = S_ACTIVE;
                if (valid_i) begin
                    w_rem_nxt  = w_rem_upd;
                    w_pow_nxt  = mode_i ? w_pow_upd : w_pow_base;
                    w_bits_nxt = w_bits_upd;
                end else begin
                    w_rem_nxt  = '0;
                    w_pow_nxt  = w_pow_base;
                    w_bits_nxt = '0;
                end
            end
        end else if (r_state == S_ACTIVE && valid_i) begin
            w_rem_nxt  = w_rem_upd;
            w_pow_nxt  = r_mode ? w_pow_upd : r_pow;
            w_bits_nxt = w_bits_upd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_pow   <= '0;
            r_n     <= '0;
            r_mode  <= 1'b0;
            r_bits  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_pow   <= w_pow_nxt;
            r_n     <= w_n_nxt;
            r_mode  <= w_mode_nxt;
            r_bits  <= w_bits_nxt;
        end
    end

    assign rem_o  = r_rem;
    assign div_o  = (r_state == S_ACTIVE) && (r_rem == '0);
    assign bits_o = r_bits;
    assign busy_o = (r_state == S_ACTIVE);
    assign err_o  = (r_state == S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_serial_mod_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_mod_checker
//  Purpose  : Directed self-checking bench for serial_mod_checker.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_mod_checker;

    localparam int DIV_W = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_i;
    logic [DIV_W-1:0] div_val_i;
    logic             mode_i;
    logic             valid_i;
    logic             x_i;
    logic [DIV_W-1:0] rem_o;
    logic             div_o;
    logic [CNT_W-1:0] bits_o;
    logic             busy_o;
    logic             err_o;

    int n_tests = 0;
    int n_fail  = 0;

    serial_mod_checker #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .div_val_i (div_val_i),
        .mode_i    (mode_i),
        .valid_i   (valid_i),
        .x_i       (x_i),
        .rem_o     (rem_o),
        .div_o     (div_o),
        .bits_o    (bits_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        start_i = 1'b0;
        valid_i = 1'b0;
    endtask

    task automatic do_start(input logic [DIV_W-1:0] n, input logic m);
        start_i   = 1'b1;
        div_val_i = n;
        mode_i    = m;
        tick();
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({rem_o, div_o, bits_o, busy_o, err_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rem=%0d div=%0b bits=%0d busy=%0b err=%0b want all 0",
                     rem_o, div_o, bits_o, busy_o, err_o);
        end
        reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            x_i     = 1'b1;
            tick();
        end
        n_tests++;
        if (bits_o !== 4'd0 || busy_o !== 1'b0 || div_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignores_valid: got bits=%0d busy=%0b div=%0b want 0 0 0",
                     bits_o, busy_o, div_o);
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] bits_v = 4'b1101;
        logic [3:0] exp_rem_v [4] = '{4'd1, 4'd0, 4'd0, 4'd1};
        logic       exp_div_v [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_start(8'd3, 1'b0);
        n_tests++;
        if (busy_o !== 1'b1 || rem_o !== 8'd0 || div_o !== 1'b1 || bits_o !== 4'd0) begin
            n_fail++;
            $display("FAIL msb_after_start: got busy=%0b rem=%0d div=%0b bits=%0d want 1 0 1 0",
                     busy_o, rem_o, div_o, bits_o);
        end
        div_val_i = 8'd5;
        mode_i    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            x_i     = bits_v[3-i];
            tick();
            n_tests++;
            if (rem_o !== 8'(exp_rem_v[i]) || div_o !== exp_div_v[i] || bits_o !== 4'(i + 1)) begin
                n_fail++;
                $display("FAIL msb_n3_bit%0d: got rem=%0d div=%0b bits=%0d want rem=%0d div=%0b bits=%0d",
                         i, rem_o, div_o, bits_o, exp_rem_v[i], exp_div_v[i], i + 1);
            end
        end
        tick();
        n_tests++;
        if (rem_o !== 8'd1 || bits_o !== 4'd4) begin
            n_fail++;
            $display("FAIL msb_hold: got rem=%0d bits=%0d want 1 4", rem_o, bits_o);
        end
    endtask

    task automatic test_lsb_first();
        logic [3:0] bits_v = 4'b1101;
        logic [3:0] exp_rem_v [4] = '{4'd1, 4'd1, 4'd0, 4'd3};
        logic       exp_div_v [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_start(8'd5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            x_i     = bits_v[i];
            tick();
            n_tests++;
            if (rem_o !== 8'(exp_rem_v[i]) || div_o !== exp_div_v[i]) begin
                n_fail++;
                $display("FAIL lsb_n5_bit%0d: got rem=%0d div=%0b want rem=%0d div=%0b",
                         i, rem_o, div_o, exp_rem_v[i], exp_div_v[i]);
            end
        end
    endtask

    task automatic test_err();
        do_start(8'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1;
            x_i     = 1'b1;
            tick();
            n_tests++;
            if (err_o !== 1'b1 || busy_o !== 1'b0 || rem_o !== 8'd0 || bits_o !== 4'd0 || div_o !== 1'b0) begin
                n_fail++;
                $display("FAIL err_state%0d: got err=%0b busy=%0b rem=%0d bits=%0d div=%0b want 1 0 0 0 0",
                         i, err_o, busy_o, rem_o, bits_o, div_o);
            end
        end
        do_start(8'd7, 1'b0);
        n_tests++;
        if (err_o !== 1'b0 || div_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_exit: got err=%0b div=%0b busy=%0b want 0 1 1", err_o, div_o, busy_o);
        end
    endtask

    task automatic test_n1();
        for (int m = 0; m < 2; m++) begin
            do_start(8'd1, 1'(m));
            for (int i = 0; i < 10; i++) begin
                valid_i = 1'b1;
                x_i     = 1'($urandom_range(0, 1));
                tick();
                n_tests++;
                if (rem_o !== 8'd0 || div_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL n1_mode%0d_bit%0d: got rem=%0d div=%0b want 0 1", m, i, rem_o, div_o);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_start(8'd3, 1'b0);
        valid_i = 1'b1; x_i = 1'b1; tick();
        valid_i = 1'b1; x_i = 1'b0; tick();
        start_i   = 1'b1;
        div_val_i = 8'd2;
        mode_i    = 1'b0;
        valid_i   = 1'b1;
        x_i       = 1'b1;
        tick();
        n_tests++;
        if (rem_o !== 8'd1 || bits_o !== 4'd1 || div_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start_valid_same: got rem=%0d bits=%0d div=%0b want 1 1 0", rem_o, bits_o, div_o);
        end
        valid_i = 1'b1; x_i = 1'b1; tick();
        n_tests++;
        if (rem_o !== 8'd1 || bits_o !== 4'd2) begin
            n_fail++;
            $display("FAIL restart_next_bit: got rem=%0d bits=%0d want 1 2", rem_o, bits_o);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({rem_o, div_o, bits_o, busy_o, err_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_midstream: got rem=%0d div=%0b bits=%0d busy=%0b err=%0b want all 0",
                     rem_o, div_o, bits_o, busy_o, err_o);
        end
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_sat_255();
        int model = 0;
        int cnt   = 0;
        do_start(8'd255, 1'b0);
        for (int i = 0; i < 40; i++) begin
            valid_i = 1'b1;
            x_i     = 1'($urandom_range(0, 1));
            model   = (2 * model + int'(x_i)) % 255;
            cnt     = (cnt < 15) ? cnt + 1 : 15;
            tick();
            n_tests++;
            if (rem_o !== 8'(model) || bits_o !== 4'(cnt)) begin
                n_fail++;
                $display("FAIL sat255_bit%0d: got rem=%0d bits=%0d want rem=%0d bits=%0d",
                         i, rem_o, bits_o, model, cnt);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        start_i   = 1'b0;
        div_val_i = '0;
        mode_i    = 1'b0;
        valid_i   = 1'b0;
        x_i       = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_err();
        test_n1();
        test_back_to_back();
        test_sat_255();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
